// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data RAM for the MEM stage with byte/half/word access,
// sign extension, pipeline stall generation and misaligned/illegal access faults.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        mem_fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          mem_fault_q, mem_fault_d;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          idle, req, commit, fault, misal, ld_ok, st_ok, we;
    logic          c_rd, c_wr;
    logic [AW+1:0] c_addr;
    logic [2:0]    c_f3;
    logic [31:0]   c_wd, rword, rsh, lword, wword;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [3:0]    be;
    logic          addr_unused;

    assign addr_unused = ^addr[31:AW+2];

    always_comb begin
        idle    = state_q == IDLE;
        req     = mem_read | mem_write;
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: if (req) begin
                addr_d  = addr[AW+1:0];
                f3_d    = funct3;
                wdata_d = write_data;
                rd_d    = mem_read;
                wr_d    = mem_write;
                cnt_d   = CW'(LATENCY - 1);
                state_d = (LATENCY == 1) ? DONE : BUSY;
            end
            BUSY: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? DONE : BUSY;
            end
            default: state_d = IDLE;
        endcase
        // With LATENCY=1 the access completes straight from IDLE, so use live inputs there
        c_rd   = idle ? mem_read : rd_q;
        c_wr   = idle ? mem_write : wr_q;
        c_addr = idle ? addr[AW+1:0] : addr_q;
        c_f3   = idle ? funct3 : f3_q;
        c_wd   = idle ? write_data : wdata_q;
        idx    = c_addr[AW+1:2];
        lane   = c_addr[1:0];
        commit = !reset && state_d == DONE && state_q != DONE;
        mem_stall = !reset && ((idle && req) || state_q == BUSY);
        ld_ok  = !(c_f3 == 3'b011 || c_f3[2:1] == 2'b11);
        st_ok  = c_f3 <= 3'b010;
        misal  = (c_f3[1:0] == 2'b01 && lane[0]) || (c_f3[1:0] == 2'b10 && lane != 2'b00);
        fault  = (c_rd && c_wr) || (c_rd && !ld_ok) || (c_wr && !st_ok) || misal;
        rword  = mem[idx];
        rsh    = rword >> {lane, 3'b000};
        rbyte  = rsh[7:0];
        rhalf  = lane[1] ? rword[31:16] : rword[15:0];
        lword  = (c_f3[1:0] == 2'b00) ? {{24{rbyte[7] & !c_f3[2]}}, rbyte} :
                 (c_f3[1:0] == 2'b01) ? {{16{rhalf[15] & !c_f3[2]}}, rhalf} : rword;
        read_data_d = !commit ? read_data_q : fault ? '0 : c_rd ? lword : read_data_q;
        mem_fault_d = commit && fault;
        be     = (c_f3[1:0] == 2'b00) ? 4'b0001 << lane :
                 (c_f3[1:0] == 2'b01) ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wword  = (c_f3[1:0] == 2'b00) ? {4{c_wd[7:0]}} :
                 (c_f3[1:0] == 2'b01) ? {2{c_wd[15:0]}} : c_wd;
        we     = commit && c_wr && !fault;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            f3_q        <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            read_data_q <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            read_data_q <= read_data_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
    end

    assign read_data = read_data_q;
    assign mem_fault = mem_fault_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY=2 and LATENCY=4.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, write_data = '0;
    logic [31:0] read_data;
    logic        mem_stall, mem_fault;
    logic        rd4 = 1'b0, wr4 = 1'b0;
    logic [2:0]  f4 = 3'b010;
    logic [31:0] a4 = 32'h10, wd4 = '0;
    logic [31:0] read_data4;
    logic        stall4, fault4;
    int          n_checks = 0, n_pass = 0;
    logic [9:0]  pat;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .write_data(write_data),
        .read_data(read_data), .mem_stall(mem_stall), .mem_fault(mem_fault));

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .mem_read(rd4), .mem_write(wr4),
        .funct3(f4), .addr(a4), .write_data(wd4),
        .read_data(read_data4), .mem_stall(stall4), .mem_fault(fault4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic acc(input string tag, input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_flt);
        int n;
        @(posedge clk);
        #1;
        mem_read = r; mem_write = w; funct3 = f; addr = a; write_data = wd;
        n = 0;
        @(negedge clk);
        while (mem_stall && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({tag, " stall_cycles"}, n, 2);
        check({tag, " read_data"}, read_data, exp_rd);
        check({tag, " fault"}, {31'b0, mem_fault}, {31'b0, exp_flt});
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check({tag, " idle_fault"}, {31'b0, mem_fault}, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset read_data", read_data, 0);
        check("reset stall", {31'b0, mem_stall}, 0);
        check("reset fault", {31'b0, mem_fault}, 0);
        reset = 1'b0;
        acc("sw 10", 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        acc("lw 10", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        acc("sw 20", 0, 1, 3'b010, 32'h20, 32'h11223344, 32'hDEADBEEF, 0);
        acc("sb 21", 0, 1, 3'b000, 32'h21, 32'h12345680, 32'hDEADBEEF, 0);
        acc("lb 21", 1, 0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 0);
        acc("lbu 21", 1, 0, 3'b100, 32'h21, 32'h0, 32'h00000080, 0);
        acc("lw 20", 1, 0, 3'b010, 32'h20, 32'h0, 32'h11228044, 0);
        acc("sh 32", 0, 1, 3'b001, 32'h32, 32'hABCD8001, 32'h11228044, 0);
        acc("lh 32", 1, 0, 3'b001, 32'h32, 32'h0, 32'hFFFF8001, 0);
        acc("lhu 32", 1, 0, 3'b101, 32'h32, 32'h0, 32'h00008001, 0);
        acc("lw 13 misal", 1, 0, 3'b010, 32'h13, 32'h0, 32'h0, 1);
        acc("lw 10 after", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        acc("load f3=011", 1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
        acc("rd+wr", 1, 1, 3'b010, 32'h10, 32'h0, 32'h0, 1);
        acc("sh 11 misal", 0, 1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'h0, 1);
        acc("sb f3=100", 0, 1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
        acc("lw 410 wrap", 1, 0, 3'b010, 32'h410, 32'h0, 32'hDEADBEEF, 0);
        acc("sw 40", 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 32'hDEADBEEF, 0);
        @(posedge clk);
        #1;
        mem_write = 1'b1; funct3 = 3'b010; addr = 32'h40; write_data = 32'h99999999;
        @(negedge clk);
        @(negedge clk);
        check("busy stall", {31'b0, mem_stall}, 1);
        reset = 1'b1;
        #1;
        check("reset stall drop", {31'b0, mem_stall}, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_write = 1'b0;
        check("mid reset read_data", read_data, 0);
        acc("lw 40 kept", 1, 0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 0);
        @(posedge clk);
        #1;
        rd4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[9-i] = stall4;
        end
        rd4 = 1'b0;
        check("lat4 b2b stall pattern", {22'b0, pat}, {22'b0, 10'b1111011110});
        check("lat4 fault", {31'b0, fault4}, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
